// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised single-clock FIFO: width functions for
// the occupancy counter and the wrapping pointers, plus reset values of the
// registered status outputs.
package fifo_pkg;

   // Occupancy counter must represent 0..DEPTH inclusive
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer must address 0..DEPTH-1; never narrower than one bit
   function automatic int fifo_ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   localparam logic RST_EMPTY  = 1'b1;
   localparam logic RST_FULL   = 1'b0;
   localparam logic RST_AEMPTY = 1'b1;
   localparam logic RST_AFULL  = 1'b0;
   localparam logic RST_ERR    = 1'b0;
   localparam logic RST_VALID  = 1'b0;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping pointer register: advances by one when inc is high and wraps from
// DEPTH-1 back to 0 explicitly, so any DEPTH works (no power-of-two masking).
module fifo_wrap_ptr
   import fifo_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int PTR_W = fifo_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;

   // Next pointer: hold, increment, or wrap at the last entry
   always_comb begin
      ptr_next = ptr_reg;
      if (inc) begin
         if (ptr_reg == PTR_W'(DEPTH - 1)) begin
            ptr_next = '0;
         end else begin
            ptr_next = ptr_reg + PTR_W'(1);
         end
      end
   end

   // Pointer register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags. DEPTH need not be 2^n.
// Optional macro FIFO_FWFT_EN selects first-word fall-through output;
// without it reads have one cycle of latency through a registered rdata.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 3,
   parameter int AFULL_TH  = 2,
   parameter int AEMPTY_TH = 1,
   parameter int CNT_W     = fifo_cnt_w(DEPTH),
   parameter int PTR_W     = fifo_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rdata,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             empty_reg;
   logic             full_reg;
   logic             afull_reg;
   logic             aempty_reg;
   logic             ovf_reg;
   logic             udf_reg;
   logic             rd_acc;
   logic             wr_acc;

   // A read needs data; a write into a full FIFO only goes if a read frees a slot
   // the same edge. No pass-through: an empty FIFO rejects the read even if a write lands.
   always_comb begin
      rd_acc = rd_en & ~empty_reg;
      wr_acc = wr_en & (~full_reg | rd_acc);
   end

   fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_acc),
      .ptr (wptr)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_acc),
      .ptr (rptr)
   );

   // Occupancy after this edge; the status flags are derived from it
   always_comb begin
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage write; contents are intentionally left untouched by reset
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wptr] <= wdata;
      end
   end

   // Count and status flags, registered together so they agree every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= '0;
         empty_reg  <= RST_EMPTY;
         full_reg   <= RST_FULL;
         afull_reg  <= RST_AFULL;
         aempty_reg <= RST_AEMPTY;
      end else begin
         count_reg  <= count_next;
         empty_reg  <= (count_next == '0);
         full_reg   <= (count_next == CNT_W'(DEPTH));
         afull_reg  <= (count_next >= CNT_W'(AFULL_TH));
         aempty_reg <= (count_next <= CNT_W'(AEMPTY_TH));
      end
   end

   // Sticky error flags; a new violation beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= RST_ERR;
         udf_reg <= RST_ERR;
      end else begin
         if (wr_en && !wr_acc) begin
            ovf_reg <= 1'b1;
         end else if (clr_err) begin
            ovf_reg <= 1'b0;
         end
         if (rd_en && !rd_acc) begin
            udf_reg <= 1'b1;
         end else if (clr_err) begin
            udf_reg <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   // Head of queue is always on display; rd_en just acknowledges it
   assign rdata    = mem[rptr];
   assign rd_valid = ~empty_reg;
`else
   logic [WIDTH-1:0] rdata_reg;
   logic             rd_valid_reg;

   // Registered read port: popped word appears after the accepting edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg    <= '0;
         rd_valid_reg <= RST_VALID;
      end else begin
         rd_valid_reg <= rd_acc;
         if (rd_acc) begin
            rdata_reg <= mem[rptr];
         end
      end
   end

   assign rdata    = rdata_reg;
   assign rd_valid = rd_valid_reg;
`endif

   assign count        = count_reg;
   assign empty        = empty_reg;
   assign full         = full_reg;
   assign almost_full  = afull_reg;
   assign almost_empty = aempty_reg;
   assign overflow     = ovf_reg;
   assign underflow    = udf_reg;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo (WIDTH=4, DEPTH=3, AFULL_TH=2, AEMPTY_TH=1).
// Works with and without FIFO_FWFT_EN; a queue-based reference model is
// updated every cycle and every output is compared against it.
module tb_param_sync_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 3;
   localparam int AFULL_TH = 2;
   localparam int AEMPTY_TH = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wdata = '0;
   logic             rd_en = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] rdata;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [1:0]       count;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   param_sync_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wdata        (wdata),
      .rd_en        (rd_en),
      .rdata        (rdata),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_rdata = '0;
   logic             m_valid = 1'b0;
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic wr, input logic [WIDTH-1:0] wd,
                               input logic rd, input logic clr, input logic rs);
      bit ra;
      bit wa;
      logic [WIDTH-1:0] popped;
      if (rs) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rdata = '0;
         m_valid = 1'b0;
      end else begin
         ra = rd && (q.size() > 0);
         wa = wr && ((q.size() < DEPTH) || ra);
         if (ra) begin
            popped = q.pop_front();
`ifndef FIFO_FWFT_EN
            m_rdata = popped;
`endif
         end
`ifndef FIFO_FWFT_EN
         m_valid = ra;
`endif
         if (wa) q.push_back(wd);
         if (wr && !wa) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (rd && !ra) m_udf = 1'b1;
         else if (clr) m_udf = 1'b0;
      end
`ifdef FIFO_FWFT_EN
      m_valid = (q.size() > 0);
      if (m_valid) m_rdata = q[0];
`endif
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      chk("count", int'(count), n);
      chk("empty", int'(empty), int'(n == 0));
      chk("full", int'(full), int'(n == DEPTH));
      chk("almost_full", int'(almost_full), int'(n >= AFULL_TH));
      chk("almost_empty", int'(almost_empty), int'(n <= AEMPTY_TH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
      chk("rd_valid", int'(rd_valid), int'(m_valid));
`ifdef FIFO_FWFT_EN
      if (m_valid) chk("rdata", int'(rdata), int'(m_rdata));
`else
      chk("rdata", int'(rdata), int'(m_rdata));
`endif
   endtask

   // One clock cycle: drive, take the edge, update the model, compare
   task automatic step(input logic wr, input logic [WIDTH-1:0] wd,
                       input logic rd, input logic clr, input logic rs);
      wr_en = wr;
      wdata = wd;
      rd_en = rd;
      clr_err = clr;
      rst = rs;
      @(posedge clk);
      #1;
      model_update(wr, wd, rd, clr, rs);
      compare_all();
      $display("cyc rst=%0b wr=%0b wd=%h rd=%0b clr=%0b -> cnt=%0d rdata=%h vld=%0b ovf=%0b udf=%0b",
               rs, wr, wd, rd, clr, count, rdata, rd_valid, overflow, underflow);
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr_err = 1'b0;
      rst = 1'b0;
   endtask

   typedef struct {
      logic             wr;
      logic [WIDTH-1:0] wd;
      logic             rd;
      logic             clr;
      int               cnt;
      logic             ovf;
      logic             udf;
   } vec_t;

   vec_t tbl[25];

   initial begin
      // wr  wd     rd    clr  | cnt ovf udf
      tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 4'hB, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'hC, 1'b0, 1'b0, 3, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 4'hF, 1'b0, 1'b0, 3, 1'b1, 1'b0};  // write when full
      tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2, 1'b1, 1'b0};  // pop A
      tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0};  // pop B
      tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b0};  // pop C
      tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b1, 1'b1};  // read when empty
      tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0};  // clear both
      tbl[9]  = '{1'b1, 4'hD, 1'b0, 1'b0, 1, 1'b0, 1'b0};  // wptr wrapped
      tbl[10] = '{1'b1, 4'hE, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1, 1'b0, 1'b0};  // pop D
      tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0};  // pop E
      tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 0, 1'b0, 1'b1};  // set beats clear
      tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 4'h1, 1'b1, 1'b0, 1, 1'b0, 1'b1};  // wr+rd at empty
      tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 4'h2, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 4'h3, 1'b0, 1'b0, 3, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 4'h4, 1'b1, 1'b0, 3, 1'b0, 1'b0};  // wr+rd at full
      tbl[20] = '{1'b1, 4'h5, 1'b1, 1'b0, 3, 1'b0, 1'b0};
      tbl[21] = '{1'b1, 4'h6, 1'b0, 1'b1, 3, 1'b1, 1'b0};  // overflow beats clear
      tbl[22] = '{1'b0, 4'h0, 1'b1, 1'b0, 2, 1'b1, 1'b0};  // pop 3
      tbl[23] = '{1'b0, 4'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0};  // pop 4
      tbl[24] = '{1'b1, 4'h7, 1'b0, 1'b0, 2, 1'b1, 1'b0};  // leaves 5,7 queued

      // Reset state
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_udf", int'(underflow), 0);

      // Directed vector table
      for (int i = 0; i < 25; i++) begin
         step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr, 1'b0);
         chk($sformatf("tbl%0d_cnt", i), int'(count), tbl[i].cnt);
         chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
         chk($sformatf("tbl%0d_udf", i), int'(underflow), int'(tbl[i].udf));
      end

      // Reset mid-stream with two words queued: old words must vanish
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_ovf", int'(overflow), 0);
      step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
      chk("post_rst_head", int'(rdata), 8);
`endif
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
      chk("post_rst_pop", int'(rdata), 8);
`endif
      chk("post_rst_empty", int'(empty), 1);

      // Randomised traffic against the model
      for (int i = 0; i < 150; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
